// File: rtl/comprobador_tabla.sv
// Response analyser: sweeps every input vector into the circuit under test and
// compares the captured outputs against a programmable expected truth table.
module comprobador_tabla #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 6,
  parameter int SETTLE = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_exp_we,
  input  logic [N_IN-1:0]   i_exp_addr,
  input  logic [N_OUT-1:0]  i_exp_data,
  output logic [N_IN-1:0]   o_estim,
  input  logic [N_OUT-1:0]  i_resp,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [N_IN:0]     o_err_count,
  output logic              o_first_err_valid,
  output logic [N_IN-1:0]   o_first_err_addr
);

  localparam int              DEPTH       = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           r_state;
  logic [N_OUT-1:0] r_table [DEPTH];
  logic [N_IN-1:0]  r_k;
  logic [3:0]       r_settle;

  logic             w_mismatch;
  logic [N_IN:0]    w_err_next;

  assign o_estim    = r_k;
  assign w_mismatch = (i_resp != r_table[r_k]);
  assign w_err_next = o_err_count + (N_IN+1)'(w_mismatch);

  // Writes are only accepted while no run is using the table.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (i_exp_we && !o_busy) begin
      r_table[i_exp_addr] <= i_exp_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= IDLE;
      r_k               <= '0;
      r_settle          <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_pass            <= 1'b0;
      o_err_count       <= '0;
      o_first_err_valid <= 1'b0;
      o_first_err_addr  <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state           <= DRIVE;
            r_k               <= '0;
            r_settle          <= '0;
            o_busy            <= 1'b1;
            o_pass            <= 1'b0;
            o_err_count       <= '0;
            o_first_err_valid <= 1'b0;
            o_first_err_addr  <= '0;
          end
        end
        DRIVE: begin
          if (r_settle == SETTLE_LAST) begin
            r_settle <= '0;
            r_state  <= SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        SAMPLE: begin
          o_err_count <= w_err_next;
          if (w_mismatch && !o_first_err_valid) begin
            o_first_err_valid <= 1'b1;
            o_first_err_addr  <= r_k;
          end
          // The verdict uses the count including this final comparison.
          if (r_k == LAST_VEC) begin
            r_state <= DONE;
            r_k     <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_pass  <= (w_err_next == '0);
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= DRIVE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
